// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream_mux family.
// Holds the arbitration mode encodings and the helper that sizes channel
// index fields, so the top level and the arbiter agree on widths.
package stream_mux_pkg;

    // Arbitration mode encodings, as driven on the mode port.
    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    // Width of a channel index for n channels. This is never narrower than
    // one bit, so a degenerate single-channel build still has a legal port.
    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter: purely combinational N-way arbiter for stream_mux_rr.
// Ports:
//   req       - per-channel request (in_valid)
//   ptr       - round-robin start index (ignored in fixed-priority mode)
//   mode      - MODE_RR or MODE_FIXED
//   lock      - a packet is in flight; only lock_idx may be granted
//   lock_idx  - channel that owns the current packet
//   grant     - one-hot grant, or zero when nothing can be granted
//   grant_idx - binary index of the granted channel (0 when no grant)
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int N     = 4,
    localparam int SEL_W = sel_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             mode,
    input  logic             lock,
    input  logic [SEL_W-1:0] lock_idx,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] grant_idx
);

    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] mask;
    logic [2*N-1:0] masked;
    int             start;
    logic           found;

    // Requests are laid out twice side by side, so a scan that begins at
    // the pointer and runs upward wraps past N-1 back to 0 without modulo logic.
    assign req_dbl = {req, req};

    // Mask off every position below the scan start. Fixed priority is a
    // round-robin scan that always starts at channel 0.
    always_comb begin
        start = (mode == MODE_FIXED) ? 0 : int'(ptr);
        mask  = '0;
        for (int j = 0; j < 2 * N; j++) begin
            mask[j] = (j >= start);
        end
    end

    assign masked = req_dbl & mask;

    // A locked packet owns the output outright. Even when its channel is
    // idle, no other requester is considered. When unlocked, the first
    // surviving bit of the masked double-width vector wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        if (lock) begin
            for (int i = 0; i < N; i++) begin
                if (SEL_W'(i) == lock_idx && req[i]) begin
                    grant[i]  = 1'b1;
                    grant_idx = lock_idx;
                end
            end
        end else begin
            for (int j = 0; j < 2 * N; j++) begin
                if (!found && masked[j]) begin
                    found          = 1'b1;
                    grant[j % N]   = 1'b1;
                    grant_idx      = SEL_W'(j % N);
                end
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream multiplexer with per-packet
// channel locking, round-robin or fixed-priority arbitration, and a
// registered one-beat output buffer that sustains one beat per cycle.
// Ports:
//   clk, rst   - rising-edge clock, synchronous active-high reset
//   mode       - 0 round-robin, 1 fixed priority (lowest index wins)
//   in_valid   - per-channel beat valid
//   in_data    - channel i occupies bits [i*W +: W]
//   in_last    - per-channel end-of-packet flag
//   in_ready   - per-channel accept, one-hot or zero
//   out_valid, out_data, out_last - registered output beat
//   out_sel    - channel that produced the current output beat
//   out_ready  - consumer accept
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int W     = 8,
    localparam int SEL_W = sel_width(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [N-1:0]     in_valid,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_last,
    output logic [N-1:0]     in_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic             out_last,
    output logic [SEL_W-1:0] out_sel,
    input  logic             out_ready
);

    logic             load;
    logic             xfer;
    logic [N-1:0]     grant;
    logic [SEL_W-1:0] grant_idx;
    logic [W-1:0]     sel_data;
    logic             sel_last;
    logic [SEL_W-1:0] ptr_next;
    logic [SEL_W-1:0] rr_ptr;
    logic             lock;
    logic [SEL_W-1:0] lock_idx;

    // The output register can take a new beat when it is empty or is being
    // drained this very cycle.
    assign load = !out_valid || out_ready;

    rr_arbiter #(
        .N (N)
    ) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .mode      (mode),
        .lock      (lock),
        .lock_idx  (lock_idx),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Grants only ever cover valid channels, so any ready bit means a transfer.
    assign in_ready = (load && !rst) ? grant : '0;
    assign xfer     = |in_ready;

    // AND-OR select on the one-hot grant. Unselected channels contribute
    // nothing, so their data cannot leak into the output.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_data = sel_data | in_data[i*W +: W];
                sel_last = sel_last | in_last[i];
            end
        end
    end

    // After a packet ends, the pointer moves to the channel just past the one that sent it.
    assign ptr_next = (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + 1'b1;

    // Output buffer, round-robin pointer and packet lock. The lock and the
    // pointer change only on an accepted beat. A last beat releases the
    // lock and advances the pointer. Any other beat pins the channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
            rr_ptr    <= '0;
            lock      <= 1'b0;
            lock_idx  <= '0;
        end else if (load) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= sel_data;
                out_last <= sel_last;
                out_sel  <= grant_idx;
                if (sel_last) begin
                    lock   <= 1'b0;
                    rr_ptr <= ptr_next;
                end else begin
                    lock     <= 1'b1;
                    lock_idx <= grant_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr (N=4, W=8).
// Each step drives one cycle of inputs together with the in_ready pattern
// expected for that cycle. An accepted beat is pushed to a scoreboard, and
// each beat on the output is compared with the head of the scoreboard.
module tb_stream_mux_rr;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int SEL_W = 2;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             mode      = 1'b0;
    logic [N-1:0]     in_valid  = '0;
    logic [N*W-1:0]   in_data   = '0;
    logic [N-1:0]     in_last   = '0;
    logic [N-1:0]     in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic             out_last;
    logic [SEL_W-1:0] out_sel;
    logic             out_ready = 1'b0;

    typedef struct packed {
        logic [W-1:0]     data;
        logic             last;
        logic [SEL_W-1:0] sel;
    } beat_t;

    typedef struct {
        logic         mode;
        logic [N-1:0] valid;
        logic [N-1:0] last;
        logic         oready;
        logic [N-1:0] exp_ready;
    } vec_t;

    beat_t        sb[$];
    logic         m_out_valid = 1'b0;
    logic [W-1:0] chd[N];
    vec_t         tbl[13];
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(
        .N (N),
        .W (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Compares this cycle's in_ready and output beat, then advances the expected output state.
    task automatic checkOutput(input string tag, input logic [N-1:0] exp_ready);
        logic  load;
        beat_t b;
        check({tag, " in_ready"}, 32'(in_ready), 32'(exp_ready));
        check({tag, " out_valid"}, 32'(out_valid), 32'(m_out_valid));
        load = !m_out_valid || out_ready;
        if (m_out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL %s scoreboard: got empty expected a beat", tag);
            end else begin
                check({tag, " out_data"}, 32'(out_data), 32'(sb[0].data));
                check({tag, " out_last"}, 32'(out_last), 32'(sb[0].last));
                check({tag, " out_sel"}, 32'(out_sel), 32'(sb[0].sel));
                if (out_ready) void'(sb.pop_front());
            end
        end
        if (load) begin
            m_out_valid = (exp_ready != '0);
            for (int g = 0; g < N; g++) begin
                if (exp_ready[g]) begin
                    b.data = chd[g];
                    b.last = in_last[g];
                    b.sel  = SEL_W'(g);
                    sb.push_back(b);
                end
            end
        end
    endtask

    // Drives one cycle of inputs at the falling edge, then checks once they have settled.
    task automatic applyStimulus(input logic m, input logic [N-1:0] v, input logic [N-1:0] l,
                                 input logic ordy, input logic [N-1:0] exp_ready, input string tag);
        @(negedge clk);
        rst       = 1'b0;
        mode      = m;
        in_valid  = v;
        in_last   = l;
        out_ready = ordy;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = chd[i];
        #1;
        checkOutput(tag, exp_ready);
    endtask

    // Holds reset for one cycle with the given valids, then checks the cleared outputs.
    task automatic doReset(input logic [N-1:0] v, input string tag);
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = v;
        in_last   = '1;
        out_ready = 1'b1;
        #1;
        check({tag, " in_ready"}, 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        check({tag, " out_valid"}, 32'(out_valid), 32'h0);
        check({tag, " out_data"}, 32'(out_data), 32'h0);
        check({tag, " out_last"}, 32'(out_last), 32'h0);
        check({tag, " out_sel"}, 32'(out_sel), 32'h0);
        sb.delete();
        m_out_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) chd[i] = W'(8'hA0 + i);

        // mode, valid, last, out_ready, expected in_ready
        tbl[0]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001};
        tbl[1]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0010};
        tbl[2]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0100};
        tbl[3]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1000};
        tbl[4]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001};
        tbl[5]  = '{1'b1, 4'b1010, 4'b1111, 1'b1, 4'b0010};
        tbl[6]  = '{1'b1, 4'b1010, 4'b1111, 1'b1, 4'b0010};
        tbl[7]  = '{1'b1, 4'b1010, 4'b1111, 1'b1, 4'b0010};
        tbl[8]  = '{1'b1, 4'b1010, 4'b0000, 1'b1, 4'b0010};
        tbl[9]  = '{1'b0, 4'b1010, 4'b0000, 1'b1, 4'b0010};
        tbl[10] = '{1'b0, 4'b1010, 4'b0010, 1'b1, 4'b0010};
        tbl[11] = '{1'b0, 4'b1010, 4'b1111, 1'b1, 4'b1000};
        tbl[12] = '{1'b0, 4'b0000, 4'b1111, 1'b1, 4'b0000};

        doReset(4'b1111, "reset0");
        doReset(4'b1111, "reset1");

        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i].mode, tbl[i].valid, tbl[i].last, tbl[i].oready,
                          tbl[i].exp_ready, $sformatf("vec%0d", i));
        end

        // ch2 three-beat packet with a valid gap, while the other channels wait
        applyStimulus(1'b0, 4'b0010, 4'b1111, 1'b1, 4'b0010, "pkt_setup");
        applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0100, "pkt_b1");
        applyStimulus(1'b0, 4'b1011, 4'b0000, 1'b1, 4'b0000, "pkt_gap");
        applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0100, "pkt_b2");
        applyStimulus(1'b0, 4'b1111, 4'b0100, 1'b1, 4'b0100, "pkt_b3");
        applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1000, "pkt_next");

        // backpressure: a held 5C beat must stay stable for five cycles
        chd[0] = 8'h5C;
        applyStimulus(1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, "bp_load");
        chd[0] = 8'hA0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0000, $sformatf("bp_hold%0d", i));
        end
        applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0010, "bp_release");
        applyStimulus(1'b0, 4'b0000, 4'b1111, 1'b1, 4'b0000, "bp_drain");

        // reset in the middle of a locked ch3 packet
        applyStimulus(1'b0, 4'b1000, 4'b0000, 1'b1, 4'b1000, "rstpkt_b1");
        applyStimulus(1'b0, 4'b1000, 4'b0000, 1'b1, 4'b1000, "rstpkt_b2");
        doReset(4'b1111, "rstpkt_rst");
        applyStimulus(1'b0, 4'b1001, 4'b1001, 1'b1, 4'b0001, "post_rst0");
        applyStimulus(1'b0, 4'b1001, 4'b1001, 1'b1, 4'b1000, "post_rst1");
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, "post_rst2");
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, "post_rst3");

        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
